// File: rtl/inside_seq_ctrl_if.sv
// Bus between inside_seq_ctrl and its environment: anchor record writes, run
// control, the time-shared inside_ datapath connection and the run result.
// master = environment side (testbench / parent), slave = sequencer side.
interface inside_seq_ctrl_if #(
    parameter int N  = 8,
    parameter int NA = 3
);
    localparam int AW = (NA > 1) ? $clog2(NA) : 1;

    logic              anc_wr;
    logic [AW-1:0]     anc_addr;
    logic [3*N:0]      anc_data;
    logic              start;
    logic [4*N+9:0]    xD;
    logic [3*N+6:0]    yD;
    logic              busy;
    logic [7*N+16:0]   dp_g_input;
    logic [3*N:0]      dp_e_input;
    logic              dp_o;
    logic              done;
    logic [NA-1:0]     in_mask;
    logic              all_in;

    modport master (
        output anc_wr, anc_addr, anc_data, start, xD, yD, dp_o,
        input  busy, dp_g_input, dp_e_input, done, in_mask, all_in
    );

    modport slave (
        input  anc_wr, anc_addr, anc_data, start, xD, yD, dp_o,
        output busy, dp_g_input, dp_e_input, done, in_mask, all_in
    );
endinterface

// File: rtl/inside_seq_ctrl.sv
// inside_seq_ctrl: time-shares one inside_ point-in-circle datapath across NA
// anchors. Each run presents anchor records one at a time (DP_LAT+1 cycles
// each), samples dp_o into in_mask and reports all_in = &in_mask with a
// one-cycle done pulse.
// Optional feature macro: INSIDE_SEQ_EARLY_EXIT_EN -- when defined, the run
// ends at the first anchor whose sampled dp_o is 0.
module inside_seq_ctrl #(
    parameter int N      = 8,
    parameter int NA     = 3,
    parameter int DP_LAT = 0
) (
    input  logic             clk,
    input  logic             rst,
    inside_seq_ctrl_if.slave bus
);
    localparam int AW = (NA > 1) ? $clog2(NA) : 1;
    localparam int CW = (DP_LAT > 0) ? $clog2(DP_LAT + 1) : 1;
    localparam int RW = 3*N + 1;
    localparam int XW = 4*N + 10;
    localparam int YW = 3*N + 7;
    localparam int GW = 7*N + 17;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   idx, idx_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [NA-1:0]   mask, mask_nxt;
    logic [RW-1:0]   anc [NA];
    logic [XW-1:0]   xd_lat;
    logic [YW-1:0]   yd_lat;
    logic [GW-1:0]   dp_g_p1, dp_g_nxt;
    logic [RW-1:0]   dp_e_p1, dp_e_nxt;
    logic            load_d;
    logic            anc_we;
    logic            early_fail;

    // Anchor writes are only honoured while idle and for in-range indices.
    assign anc_we = bus.anc_wr && (state == IDLE) &&
                    ({1'b0, bus.anc_addr} < (AW+1)'(NA));

`ifdef INSIDE_SEQ_EARLY_EXIT_EN
    assign early_fail = ~bus.dp_o;
`else
    assign early_fail = 1'b0;
`endif

    // Anchor record store; stable for the whole run because writes need IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NA; i++) begin
                anc[i] <= '0;
            end
        end else if (anc_we) begin
            anc[bus.anc_addr] <= bus.anc_data;
        end
    end

    // FSM state, anchor index, window counter, result mask and datapath drive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            cnt     <= '0;
            mask    <= '0;
            dp_g_p1 <= '0;
            dp_e_p1 <= '0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            cnt     <= cnt_nxt;
            mask    <= mask_nxt;
            dp_g_p1 <= dp_g_nxt;
            dp_e_p1 <= dp_e_nxt;
        end
    end

    // Target point latches, captured when a run is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xd_lat <= '0;
            yd_lat <= '0;
        end else if (load_d) begin
            xd_lat <= bus.xD;
            yd_lat <= bus.yD;
        end
    end

    // Next-state and next datapath drive; the datapath inputs are registered
    // one edge ahead so they are stable from the first cycle of each window.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        mask_nxt  = mask;
        dp_g_nxt  = '0;
        dp_e_nxt  = '0;
        load_d    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = RUN;
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                    mask_nxt  = '0;
                    load_d    = 1'b1;
                    dp_g_nxt  = {bus.xD, bus.yD};
                    // A same-cycle write to anchor 0 must reach the first window.
                    dp_e_nxt  = (anc_we && (bus.anc_addr == '0)) ? bus.anc_data : anc[0];
                end
            end
            RUN: begin
                dp_g_nxt = {xd_lat, yd_lat};
                dp_e_nxt = anc[idx];
                if (cnt == CW'(DP_LAT)) begin
                    mask_nxt[idx] = bus.dp_o;
                    cnt_nxt       = '0;
                    if ((idx == AW'(NA - 1)) || early_fail) begin
                        state_nxt = DONE;
                        dp_g_nxt  = '0;
                        dp_e_nxt  = '0;
                    end else begin
                        idx_nxt  = idx + 1'b1;
                        dp_e_nxt = anc[idx_nxt];
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.busy       = (state != IDLE);
    assign bus.done       = (state == DONE);
    assign bus.in_mask    = mask;
    assign bus.all_in     = &mask;
    assign bus.dp_g_input = dp_g_p1;
    assign bus.dp_e_input = dp_e_p1;
endmodule
